// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, FSM states and the iteration-counter width.
package alu_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Counter only needs to reach WIDTH-1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/alu_muldiv_dp.sv
// Datapath for alu_muldiv: 2*WIDTH accumulator, shift-add multiply,
// restoring divide and the final sign fix-up of HI/LO results.
module alu_muldiv_dp
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             zero_div,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   op_e                 op_q;
   logic                sa;
   logic                sb;
   logic [2*WIDTH-1:0]  acc;
   logic [WIDTH-1:0]    opb;

   logic                sgn_in;
   logic [WIDTH-1:0]    abs_a;
   logic [WIDTH-1:0]    abs_b;
   logic [WIDTH:0]      mul_sum;
   logic [2*WIDTH-1:0]  mul_next;
   logic [2*WIDTH:0]    div_sh;
   logic [WIDTH:0]      div_trial;
   logic [2*WIDTH-1:0]  div_next;
   logic                is_signed;
   logic                is_div;
   logic                neg_main;
   logic                neg_rem;
   logic [2*WIDTH-1:0]  prod_fix;
   logic [WIDTH-1:0]    quo;
   logic [WIDTH-1:0]    rem;

   assign sgn_in = op[0];
   assign abs_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
   assign abs_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);

   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
   end

   // Shift first, then trial-subtract; the extra top bit keeps the
   // shifted partial remainder exact before the compare.
   always_comb begin
      div_sh    = {acc, 1'b0};
      div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opb};
      if (!div_trial[WIDTH]) begin
         div_next = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
      end else begin
         div_next = div_sh[2*WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q <= OP_MULTU;
         sa   <= 1'b0;
         sb   <= 1'b0;
         acc  <= '0;
         opb  <= '0;
      end else if (load) begin
         op_q <= op_e'(op);
         sa   <= sgn_in & a[WIDTH-1];
         sb   <= sgn_in & b[WIDTH-1];
         acc  <= {{WIDTH{1'b0}}, abs_a};
         opb  <= abs_b;
      end else if (step) begin
         acc <= is_div ? div_next : mul_next;
      end
   end

   assign neg_main = is_signed & (sa ^ sb);
   assign neg_rem  = is_signed & sa;
   assign prod_fix = neg_main ? -acc : acc;
   assign quo      = acc[WIDTH-1:0];
   assign rem      = acc[2*WIDTH-1:WIDTH];

   // On divide-by-zero the accumulator was never stepped, so its low half
   // still holds |a| and re-applying the sign recovers the original a.
   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (zero_div) begin
         res_hi = neg_rem ? -quo : quo;
         res_lo = '1;
      end else if (is_div) begin
         res_hi = neg_rem ? -rem : rem;
         res_lo = neg_main ? -quo : quo;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS
// execute stage; the FSM, iteration counter and HI/LO live here.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             dz_pend;
   logic             hold;
   logic             load;
   logic             step;
   logic             div_zero_req;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   assign div_zero_req = op[1] && (b == '0);
   assign load         = (state == ST_IDLE) && start;
   assign step         = (state == ST_CALC);

   alu_muldiv_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .op       (op),
      .a        (a),
      .b        (b),
      .zero_div (dz_pend),
      .res_hi   (res_hi),
      .res_lo   (res_lo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         dz_pend <= 1'b0;
         hold    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dz      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  dz      <= 1'b0;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  dz_pend <= div_zero_req;
                  hold    <= div_zero_req;
                  state   <= div_zero_req ? ST_FIX : ST_CALC;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            ST_CALC: begin
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  cnt   <= '0;
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIX: begin
               // Divide-by-zero spends one extra cycle here so its result
               // lands two edges after acceptance.
               if (hold) begin
                  hold <= 1'b0;
               end else begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  dz    <= dz_pend;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): transaction-level latency
// model compared every cycle, plus directed vectors with literal results.
module tb_alu_muldiv;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wdata;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         dz;

   int errs   = 0;
   int checks = 0;

   alu_muldiv #(
      .WIDTH(W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec-level arithmetic: 64-bit products and truncating signed division.
   task automatic compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
      logic [63:0] p;
      longint      q;
      longint      r;
      rz = 1'b0;
      if (o[1] && y == '0) begin
         rh = x;
         rl = '1;
         rz = 1'b1;
      end else begin
         case (o)
            2'b00: begin p = 64'(x) * 64'(y); rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin
               p  = 64'(longint'($signed(x)) * longint'($signed(y)));
               rh = p[63:32];
               rl = p[31:0];
            end
            2'b10: begin rl = x / y; rh = x % y; end
            default: begin
               q  = longint'($signed(x)) / longint'($signed(y));
               r  = longint'($signed(x)) % longint'($signed(y));
               rl = q[31:0];
               rh = r[31:0];
            end
         endcase
      end
   endtask

   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   logic         m_busy, m_done, m_dz, p_dz;
   int           remaining = 0;
   logic         m_ok = 1'b0;

   initial begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0;
      p_hi = '0; p_lo = '0; p_dz = 0;
   end

   always @(posedge clk) begin
      m_ok = 1'b1;
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0;
         remaining = 0;
      end else begin
         m_done = 1'b0;
         if (remaining == 0) begin
            if (start) begin
               compute(op, a, b, p_hi, p_lo, p_dz);
               m_dz      = 1'b0;
               m_busy    = 1'b1;
               remaining = p_dz ? 2 : W + 1;
            end else begin
               if (hi_we) m_hi = wdata;
               if (lo_we) m_lo = wdata;
            end
         end else begin
            remaining--;
            if (remaining == 0) begin
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_dz   = p_dz;
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_hi",   64'(hi),   64'(m_hi));
         chk("model_lo",   64'(lo),   64'(m_lo));
         chk("model_busy", 64'(busy), 64'(m_busy));
         chk("model_done", 64'(done), 64'(m_done));
         chk("model_dz",   64'(dz),   64'(m_dz));
      end
   end

   // kind: 0 plain, 1 stray start in CALC, 2 lo_we in CALC, 3 hi_we with start
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input int lat, input int kind, input logic [W-1:0] hold_hi);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (kind == 3) begin hi_we = 1'b1; wdata = 32'h0000_DEAD; end
      @(posedge clk);
      #1;
      start = 1'b0; hi_we = 1'b0;
      chk("accept_busy", 64'(busy), 64'd1);
      chk("accept_dz",   64'(dz),   64'd0);
      if (kind == 3) chk("drop_hi", 64'(hi), 64'(hold_hi));
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 5 && kind == 1) begin start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; end
         if (n == 5 && kind == 2) begin lo_we = 1'b1; wdata = 32'hCAFE_0000; end
         if (n == 6) begin start = 1'b0; lo_we = 1'b0; end
      end while (!done && n < 100);
      chk("latency",  64'(n),  64'(lat));
      chk("done_hi",  64'(hi), 64'(eh));
      chk("done_lo",  64'(lo), 64'(el));
      chk("done_dz",  64'(dz), 64'(ed));
   endtask

   task automatic direct_write(input logic wh, input logic wl, input logic [W-1:0] d);
      @(negedge clk);
      hi_we = wh; lo_we = wl; wdata = d;
      @(posedge clk);
      #1;
      hi_we = 1'b0; lo_we = 1'b0;
      if (wh) chk("mthi", 64'(hi), 64'(d));
      if (wl) chk("mtlo", 64'(lo), 64'(d));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hi",   64'(hi),   64'd0);
      chk("rst_lo",   64'(lo),   64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz",   64'(dz),   64'd0);
      rst_n = 1'b1;

      run_op(2'b00, 32'd11, 32'd6, 32'd0, 32'd66, 1'b0, 33, 0, '0);
      run_op(2'b01, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 0, '0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0, '0);
      run_op(2'b10, 32'd11, 32'd6, 32'd5, 32'd1, 1'b0, 33, 0, '0);
      run_op(2'b11, -32'sd11, 32'd6, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 33, 0, '0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 0, '0);
      run_op(2'b10, 32'd8, 32'd0, 32'd8, 32'hFFFF_FFFF, 1'b1, 2, 0, '0);
      run_op(2'b11, -32'sd7, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2, 0, '0);
      run_op(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 33, 0, '0);
      run_op(2'b00, 32'd11, 32'd6, 32'd0, 32'd66, 1'b0, 33, 1, '0);
      direct_write(1'b1, 1'b0, 32'h0000_1234);
      direct_write(1'b0, 1'b1, 32'h0000_5678);
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 2, '0);
      direct_write(1'b1, 1'b0, 32'h0000_AAAA);
      run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 3, 32'h0000_AAAA);

      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_hi",   64'(hi),   64'd0);
      chk("abort_lo",   64'(lo),   64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 64'(done), 64'd0);
      end

      run_op(2'b01, 32'd7, -32'sd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33, 0, '0);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
